// File: rtl/ltc2308_responder.sv
// LTC2308 serial-side responder: converts on CONVST, shifts the result out on SDO
// and captures the config word from SDI. All pins are resynchronized into clk.
module ltc2308_responder #(
  parameter int W           = 12,
  parameter int CFG_BITS    = 6,
  parameter int CONV_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                convst,
  input  logic                sck,
  input  logic                sdi,
  output logic                sdo,
  input  logic [W-1:0]        sample_in,
  output logic [2:0]          ch_sel,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                busy,
  output logic                frame_done,
  output logic                err
);

  localparam int CW = $clog2(W + 1);
  localparam int KW = $clog2(CONV_CYCLES);
  localparam logic [KW-1:0] CONV_LAST = KW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(W - 1);
  localparam logic [CW-1:0] CFG_FULL  = CW'(CFG_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_HOLD,
    S_SHIFT
  } state_t;

  // [0],[1] form the synchronizer; [2] is the previous synced value for edge detect
  logic [2:0] convst_q;
  logic [2:0] sck_q;
  logic [1:0] sdi_q;

  state_t                state_q, state_d;
  logic [W-1:0]          dout_q, dout_d;
  logic [KW-1:0]         conv_cnt_q, conv_cnt_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [CFG_BITS-1:0]   cfg_sh_q, cfg_sh_d;
  logic [CFG_BITS-1:0]   cfg_q, cfg_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic convst_s, conv_rise, conv_fall;
  logic sck_rise, sck_fall;
  logic sdi_s;

  assign convst_s  = convst_q[1];
  assign conv_rise = convst_q[1] & ~convst_q[2];
  assign conv_fall = ~convst_q[1] & convst_q[2];
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign sdi_s     = sdi_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      convst_q <= '0;
      sck_q    <= '0;
      sdi_q    <= '0;
    end else begin
      convst_q <= {convst_q[1:0], convst};
      sck_q    <= {sck_q[1:0], sck};
      sdi_q    <= {sdi_q[0], sdi};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dout_q     <= '0;
      conv_cnt_q <= '0;
      bit_cnt_q  <= '0;
      rx_cnt_q   <= '0;
      cfg_sh_q   <= '0;
      cfg_q      <= '0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      conv_cnt_q <= conv_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      cfg_sh_q   <= cfg_sh_d;
      cfg_q      <= cfg_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    conv_cnt_d = conv_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    cfg_sh_d   = cfg_sh_q;
    cfg_d      = cfg_q;
    sdo_d      = sdo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        sdo_d = 1'b0;
        if (conv_rise) begin
          dout_d     = sample_in;
          conv_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = S_CONVERT;
        end
      end

      S_CONVERT: begin
        if (sck_rise || sck_fall) begin
          err_d = 1'b1;
        end
        if (conv_cnt_q == CONV_LAST) begin
          busy_d = 1'b0;
          if (convst_s) begin
            sdo_d   = 1'b0;
            state_d = S_HOLD;
          end else begin
            sdo_d     = dout_q[W-1];
            bit_cnt_d = '0;
            rx_cnt_d  = '0;
            state_d   = S_SHIFT;
          end
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        sdo_d = 1'b0;
        if (conv_fall) begin
          sdo_d     = dout_q[W-1];
          bit_cnt_d = '0;
          rx_cnt_d  = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // A new conversion request outranks a coincident sck fall
        if (conv_rise) begin
          dout_d     = sample_in;
          conv_cnt_d = '0;
          busy_d     = 1'b1;
          sdo_d      = 1'b0;
          state_d    = S_CONVERT;
        end else if (sck_rise) begin
          if (rx_cnt_q < CFG_FULL) begin
            cfg_sh_d = {cfg_sh_q[CFG_BITS-2:0], sdi_s};
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == BIT_LAST) begin
            sdo_d   = 1'b0;
            done_d  = 1'b1;
            if (rx_cnt_q == CFG_FULL) begin
              cfg_d = cfg_sh_q;
            end
            state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sdo_d     = dout_q[W-2];
            dout_d    = {dout_q[W-2:0], 1'b0};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign sdo        = sdo_q;
  assign cfg_out    = cfg_q;
  assign ch_sel     = cfg_q[4:2];
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Randomized scoreboard bench for ltc2308_responder: the stimulus side predicts each
// completed frame, a monitor checks SDO word, config and busy length as they appear.
module tb_ltc2308_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        convst;
  logic        sck;
  logic        sdi;
  logic        sdo;
  logic [11:0] sample_in;
  logic [2:0]  ch_sel;
  logic [5:0]  cfg_out;
  logic        busy;
  logic        frame_done;
  logic        err;

  ltc2308_responder #(.W(12), .CFG_BITS(6), .CONV_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .convst     (convst),
    .sck        (sck),
    .sdi        (sdi),
    .sdo        (sdo),
    .sample_in  (sample_in),
    .ch_sel     (ch_sel),
    .cfg_out    (cfg_out),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] res;
    logic [5:0]  cfg;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [5:0]  cfg_model = 6'd0;
  logic [11:0] sdo_win = 12'd0;
  int          busy_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // The initiator samples SDO on sck rise; keep the last 12 samples
  always @(posedge sck) sdo_win <= {sdo_win[10:0], sdo};

  always @(negedge clk) begin
    if (!rst) begin
      busy_len = 0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        check("busy_len", busy_len, 64);
        busy_len = 0;
      end
      if (frame_done) begin
        if (sb_q.size() == 0) begin
          check("frame_done_unexpected", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("sdo_word", {20'd0, sdo_win}, {20'd0, mon_e.res});
          check("cfg_out", {26'd0, cfg_out}, {26'd0, mon_e.cfg});
          check("ch_sel", {29'd0, ch_sel}, {29'd0, mon_e.cfg[4:2]});
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_conv(input logic [11:0] s, input int hold);
    sample_in = s;
    convst = 1'b1;
    clks(hold);
    convst = 1'b0;
    clks(3);
    sample_in = 12'($urandom);
  endtask

  task automatic wait_busy_low();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      clks(1);
      n++;
    end
    if (n >= 200) check("busy_timeout", 1, 0);
    clks(2);
  endtask

  task automatic shift_bits(input logic [5:0] cfg, input int n);
    for (int i = 0; i < n; i++) begin
      clks(2);
      sdi = (i < 6) ? cfg[5 - i] : 1'($urandom);
      clks(2);
      sck = 1'b1;
      clks(4);
      sck = 1'b0;
    end
  endtask

  task automatic full_frame(input logic [11:0] s, input logic [5:0] cfg, input int hold);
    exp_t e;
    start_conv(s, hold);
    wait_busy_low();
    e.res = s;
    e.cfg = cfg;
    sb_q.push_back(e);
    cfg_model = cfg;
    shift_bits(cfg, 12);
    clks(4);
    check("sdo_after_frame", {31'd0, sdo}, 0);
  endtask

  initial begin
    logic [11:0] s;
    exp_t        e;
    rst = 1'b0;
    convst = 1'b0;
    sck = 1'b0;
    sdi = 1'b0;
    sample_in = 12'd0;
    clks(3);
    check("rst_sdo", {31'd0, sdo}, 0);
    check("rst_cfg", {26'd0, cfg_out}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err", {31'd0, err}, 0);
    rst = 1'b1;
    clks(4);

    // Directed normal frame
    full_frame(12'hA5C, 6'b101100, 2);
    check("normal_ch_sel", {29'd0, ch_sel}, 32'd3);

    // Randomized frames
    for (int k = 0; k < 15; k++) begin
      full_frame(12'($urandom), 6'($urandom), 2 + int'($urandom_range(0, 3)));
    end
    check("no_err_after_clean_frames", {31'd0, err}, 0);

    // Held convst: busy ends, sdo stays 0 until convst falls
    s = 12'($urandom) | 12'h800;
    sample_in = s;
    convst = 1'b1;
    clks(10);
    sample_in = ~s;
    clks(60);
    check("hold_busy_low", {31'd0, busy}, 0);
    check("hold_sdo_zero", {31'd0, sdo}, 0);
    clks(30);
    convst = 1'b0;
    clks(4);
    check("hold_sdo_msb", {31'd0, sdo}, {31'd0, s[11]});
    e.res = s;
    e.cfg = 6'b010110;
    sb_q.push_back(e);
    cfg_model = e.cfg;
    shift_bits(e.cfg, 12);
    clks(4);

    // Premature sck during conversion
    s = 12'($urandom);
    start_conv(s, 2);
    for (int p = 0; p < 3; p++) begin
      sck = 1'b1;
      clks(4);
      sck = 1'b0;
      clks(4);
    end
    check("err_set", {31'd0, err}, 1);
    wait_busy_low();
    e.res = s;
    e.cfg = 6'($urandom);
    sb_q.push_back(e);
    cfg_model = e.cfg;
    shift_bits(e.cfg, 12);
    clks(4);
    check("err_sticky", {31'd0, err}, 1);

    // Abort after 5 falls, then a short (4-bit) config aborted likewise
    for (int a = 0; a < 2; a++) begin
      start_conv(12'($urandom), 2);
      wait_busy_low();
      shift_bits(~cfg_model, (a == 0) ? 5 : 4);
      clks(2);
      s = 12'($urandom);
      start_conv(s, 2);
      check("abort_busy", {31'd0, busy}, 1);
      check("abort_cfg_kept", {26'd0, cfg_out}, {26'd0, cfg_model});
      check("abort_ch_sel_kept", {29'd0, ch_sel}, {29'd0, cfg_model[4:2]});
      wait_busy_low();
      e.res = s;
      e.cfg = 6'($urandom);
      sb_q.push_back(e);
      cfg_model = e.cfg;
      shift_bits(e.cfg, 12);
      clks(4);
    end

    // Asynchronous reset in the middle of a frame
    start_conv(12'hFFF, 2);
    wait_busy_low();
    shift_bits(6'b111111, 3);
    clks(1);
    #2 rst = 1'b0;
    #1;
    check("arst_sdo", {31'd0, sdo}, 0);
    check("arst_cfg", {26'd0, cfg_out}, 0);
    check("arst_ch_sel", {29'd0, ch_sel}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_done", {31'd0, frame_done}, 0);
    check("arst_err", {31'd0, err}, 0);
    cfg_model = 6'd0;
    clks(3);
    rst = 1'b1;
    clks(5);
    check("post_rst_sdo", {31'd0, sdo}, 0);
    full_frame(12'($urandom), 6'($urandom), 3);
    check("post_rst_err", {31'd0, err}, 0);

    clks(10);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
